// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle between the hazard/redirect sources, pipe_ctrl and the
// PC / if_id / id_ex registers. The master side is the controller itself.
interface pipe_ctrl_if;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        ex_load_i;
    logic [4:0]  ex_rd_addr_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic        div_busy_i;
    logic        hold_req_i;

    logic        hold_ack_o;
    logic        pc_load_o;
    logic [31:0] pc_load_addr_o;
    logic        pc_stall_o;
    logic        if_id_stall_o;
    logic        if_id_flush_o;
    logic        id_ex_stall_o;
    logic        id_ex_flush_o;
    logic [1:0]  state_o;

    modport master (
        input  jump_en_i, jump_addr_i, ex_load_i, ex_rd_addr_i,
               id_rs1_addr_i, id_rs2_addr_i, div_busy_i, hold_req_i,
        output hold_ack_o, pc_load_o, pc_load_addr_o, pc_stall_o,
               if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o, state_o
    );

    modport slave (
        output jump_en_i, jump_addr_i, ex_load_i, ex_rd_addr_i,
               id_rs1_addr_i, id_rs2_addr_i, div_busy_i, hold_req_i,
        input  hold_ack_o, pc_load_o, pc_load_addr_o, pc_stall_o,
               if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o, state_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// IF/ID/EX sequencing controller: arbitrates redirect, divider busy, load-use
// and external hold, and drives PC load/stall plus if_id/id_ex stall/flush.
module pipe_ctrl #(
    parameter int unsigned FETCH_LAT    = 1,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    pipe_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [3:0] FLUSH_INIT = (FETCH_LAT == 0) ? 4'd0 : 4'(FETCH_LAT - 1);
    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       lu;

    logic pc_load;
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;

    assign lu = bus.ex_load_i && (bus.ex_rd_addr_i != 5'd0) &&
                ((bus.ex_rd_addr_i == bus.id_rs1_addr_i) ||
                 (bus.ex_rd_addr_i == bus.id_rs2_addr_i));

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pc_load     = 1'b0;
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_stall = 1'b0;
        id_ex_flush = 1'b0;

        if (bus.jump_en_i) begin
            // A redirect wins from any state, including an in-progress drain.
            pc_load     = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (FETCH_LAT == 0) begin
                state_nxt = RUN;
                cnt_nxt   = 4'd0;
            end else begin
                state_nxt = FLUSH;
                cnt_nxt   = FLUSH_INIT;
            end
        end else begin
            unique case (state)
                RUN: begin
                    if (bus.div_busy_i) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_stall = 1'b1;
                    end else if (lu) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (bus.hold_req_i) begin
                        state_nxt = DRAIN;
                        cnt_nxt   = DRAIN_INIT;
                    end
                end
                FLUSH: begin
                    if_id_flush = 1'b1;
                    if (cnt == 4'd0) state_nxt = RUN;
                    else             cnt_nxt   = cnt - 4'd1;
                end
                DRAIN: begin
                    // Bubbles keep flowing into EX unless the divider must keep its operand.
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_stall = bus.div_busy_i;
                    id_ex_flush = !bus.div_busy_i;
                    if (!bus.hold_req_i)                         state_nxt = RUN;
                    else if (!bus.div_busy_i && cnt == 4'd0)     state_nxt = HOLD;
                    else if (!bus.div_busy_i)                    cnt_nxt   = cnt - 4'd1;
                end
                HOLD: begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                    if (!bus.hold_req_i) state_nxt = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Every output is forced low while reset is asserted, combinational ones included.
    assign bus.pc_load_o      = rst_n && pc_load;
    assign bus.pc_load_addr_o = (rst_n && pc_load) ? bus.jump_addr_i : 32'd0;
    assign bus.pc_stall_o     = rst_n && pc_stall;
    assign bus.if_id_stall_o  = rst_n && if_id_stall;
    assign bus.if_id_flush_o  = rst_n && if_id_flush;
    assign bus.id_ex_stall_o  = rst_n && id_ex_stall;
    assign bus.id_ex_flush_o  = rst_n && id_ex_flush;
    assign bus.hold_ack_o     = rst_n && (state == HOLD);
    assign bus.state_o        = rst_n ? state : RUN;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios followed by random traffic, all
// compared each cycle against a mode/remaining-cycles reference model.
module tb_pipe_ctrl;
    localparam int FL = 1;
    localparam int DC = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pipe_ctrl_if bus();

    pipe_ctrl #(.FETCH_LAT(FL), .DRAIN_CYCLES(DC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: m_mode 0=run 1=refetch 2=draining 3=held; m_left counts
    // the cycles of that activity still to be served.
    int m_mode = 0;
    int m_left = 0;

    logic [40:0] obs;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {ack, pc_load, addr[31:0], pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, state[1:0]}
    function automatic logic [40:0] pack_obs();
        return {bus.hold_ack_o, bus.pc_load_o, bus.pc_load_addr_o, bus.pc_stall_o,
                bus.if_id_stall_o, bus.if_id_flush_o, bus.id_ex_stall_o,
                bus.id_ex_flush_o, bus.state_o};
    endfunction

    function automatic bit model_lu();
        return bus.ex_load_i && bus.ex_rd_addr_i != 0 &&
               (bus.ex_rd_addr_i == bus.id_rs1_addr_i || bus.ex_rd_addr_i == bus.id_rs2_addr_i);
    endfunction

    function automatic logic [40:0] model_out();
        bit ack, ld, ps, is, ifl, es, ef;
        logic [31:0] addr;
        ack = 0; ld = 0; ps = 0; is = 0; ifl = 0; es = 0; ef = 0; addr = 32'd0;
        if (!rst_n) return 41'd0;
        ack = (m_mode == 3);
        if (bus.jump_en_i) begin
            ld = 1; addr = bus.jump_addr_i; ifl = 1; ef = 1;
        end else if (m_mode == 0) begin
            if (bus.div_busy_i)  begin ps = 1; is = 1; es = 1; end
            else if (model_lu()) begin ps = 1; is = 1; ef = 1; end
        end else if (m_mode == 1) begin
            ifl = 1;
        end else if (m_mode == 2) begin
            ps = 1; is = 1;
            es = bus.div_busy_i;
            ef = !bus.div_busy_i;
        end else begin
            ps = 1; is = 1; ef = 1;
        end
        return {ack, ld, addr, ps, is, ifl, es, ef, 2'(m_mode)};
    endfunction

    function automatic void model_step();
        if (!rst_n) begin
            m_mode = 0; m_left = 0;
        end else if (bus.jump_en_i) begin
            m_mode = (FL == 0) ? 0 : 1;
            m_left = FL;
        end else begin
            case (m_mode)
                0: if (!bus.div_busy_i && !model_lu() && bus.hold_req_i) begin
                       m_mode = 2; m_left = DC;
                   end
                1: begin
                       m_left = m_left - 1;
                       if (m_left == 0) m_mode = 0;
                   end
                2: if (!bus.hold_req_i) m_mode = 0;
                   else if (!bus.div_busy_i) begin
                       m_left = m_left - 1;
                       if (m_left == 0) m_mode = 3;
                   end
                default: if (!bus.hold_req_i) m_mode = 0;
            endcase
        end
    endfunction

    task automatic step(input logic jmp, input logic [31:0] ja, input logic ld,
                        input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                        input logic div, input logic hreq);
        bus.jump_en_i     = jmp;
        bus.jump_addr_i   = ja;
        bus.ex_load_i     = ld;
        bus.ex_rd_addr_i  = rd;
        bus.id_rs1_addr_i = r1;
        bus.id_rs2_addr_i = r2;
        bus.div_busy_i    = div;
        bus.hold_req_i    = hreq;
        #4;
        obs = pack_obs();
        check("cycle_outs", 64'(obs), 64'(model_out()));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input logic hreq);
        step(1'b0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, hreq);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int ack_cyc;
        logic hreq_r;
        logic div_r;

        // Reset with jump and hold asserted: everything stays low.
        step(1'b1, 32'h80, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        check("reset_outs", 64'(obs), 64'd0);
        rst_n = 1'b1;
        step(1'b1, 32'h44, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        check("rst_release_pc_load", 64'(obs[39]), 64'd1);
        idle(1'b0);

        // Single redirect to 0x40.
        step(1'b1, 32'h40, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        check("jump_pc_load", 64'(obs[39]), 64'd1);
        check("jump_addr", 64'(obs[38:7]), 64'h40);
        check("jump_flushes", 64'({obs[4], obs[2]}), 64'd3);
        idle(1'b0);
        check("flush_state", 64'(obs[1:0]), 64'd1);
        check("flush_if_id", 64'(obs[4]), 64'd1);
        idle(1'b0);
        check("jump_back_run", 64'(obs[1:0]), 64'd0);

        // Load-use on rs2, then the load leaves EX, then x0 never hazards.
        step(1'b0, 32'd0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0);
        check("lu_bubble", 64'(obs[6:2]), 64'b11001);
        step(1'b0, 32'd0, 1'b0, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0);
        check("lu_gone", 64'(obs[6:2]), 64'd0);
        step(1'b0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        check("lu_x0", 64'(obs[6:2]), 64'd0);

        // Plain hold request: ack after DC+1 cycles.
        ack_cyc = -1;
        for (int c = 0; c < 20 && ack_cyc < 0; c++) begin
            idle(1'b1);
            if (c == 0) check("hold_req_no_stall", 64'(obs[6]), 64'd0);
            if (c == 1 || c == 2) check("drain_state", 64'(obs[1:0]), 64'd2);
            if (obs[40]) ack_cyc = c;
        end
        check("hold_latency", 64'(ack_cyc), 64'(DC + 1));
        idle(1'b0);
        check("ack_still_high", 64'(obs[40]), 64'd1);
        idle(1'b0);
        check("ack_dropped", 64'({obs[40], obs[1:0]}), 64'd0);

        // Divider busy for three cycles inside the drain.
        ack_cyc = -1;
        for (int c = 0; c < 20 && ack_cyc < 0; c++) begin
            div_r = (c >= 1 && c <= 3);
            step(1'b0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, div_r, 1'b1);
            if (div_r) check("drain_div_stall", 64'(obs[3:2]), 64'b10);
            if (obs[40]) ack_cyc = c;
        end
        check("div_hold_latency", 64'(ack_cyc), 64'd6);
        idle(1'b0);
        idle(1'b0);

        // Jump together with load-use and hold request.
        step(1'b1, 32'h100, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1);
        check("simul_pc_load", 64'(obs[39]), 64'd1);
        check("simul_no_stall", 64'({obs[6:5], obs[3]}), 64'd0);
        idle(1'b1);
        check("simul_flush", 64'(obs[1:0]), 64'd1);
        idle(1'b1);
        check("simul_run", 64'(obs[1:0]), 64'd0);
        idle(1'b1);
        check("simul_drain", 64'(obs[1:0]), 64'd2);
        step(1'b1, 32'h200, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        check("drain_jump_load", 64'(obs[39]), 64'd1);
        idle(1'b1);
        check("drain_jump_flush", 64'(obs[1:0]), 64'd1);
        idle(1'b1);
        idle(1'b1);
        check("drain_reentered", 64'(obs[1:0]), 64'd2);
        idle(1'b1);
        idle(1'b1);
        check("pre_reset_ack", 64'(obs[40]), 64'd1);

        // Asynchronous reset in the middle of HOLD.
        rst_n = 1'b0;
        #1;
        check("async_reset", 64'(pack_obs()), 64'd0);
        idle(1'b1);
        rst_n = 1'b1;
        idle(1'b0);
        check("after_reset_run", 64'({obs[40], obs[1:0]}), 64'd0);

        // Random traffic.
        hreq_r = 1'b0;
        div_r  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) hreq_r = ~hreq_r;
            if ($urandom_range(5) == 0)  div_r  = ~div_r;
            rst_n = ($urandom_range(499) != 0);
            step($urandom_range(11) == 0, $urandom, 1'($urandom_range(1)),
                 5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
                 div_r, hreq_r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
